// File: rtl/pipe_stage_reg.sv
// Pipeline stage register carrying a valid/ready payload. It is either a two-entry skid buffer
// with a registered in_ready, or a single register whose in_ready depends combinationally on out_ready.
module pipe_stage_reg #(
   parameter int unsigned              PAYLOAD_WIDTH = 160,
   parameter int unsigned              CTRL_WIDTH    = 12,
   parameter logic [CTRL_WIDTH-1:0]    BUBBLE_CTRL   = '0,
   parameter logic [PAYLOAD_WIDTH-1:0] RESET_PAYLOAD = '0,
   parameter bit                       SKID          = 1'b1
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     flush,
   input  logic                     clear_stats,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [PAYLOAD_WIDTH-1:0] in_payload,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [PAYLOAD_WIDTH-1:0] out_payload,
   output logic [1:0]               occupancy,
   output logic [15:0]              stall_cycles
);

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } state_t;

   logic [PAYLOAD_WIDTH-1:0] main_q;
   logic                     vld_q;
   logic [1:0]               occ;
   logic                     in_xfer;
   logic                     out_xfer;
   logic [15:0]              stall_q;

   assign in_xfer   = in_valid && in_ready;
   assign out_xfer  = out_valid && out_ready;
   assign out_valid = vld_q;
   assign occupancy = occ;

   generate
      if (SKID) begin : g_skid
         state_t                   state_q;
         state_t                   state_nxt;
         logic [PAYLOAD_WIDTH-1:0] skid_q;
         logic                     rdy_q;
         logic [1:0]               occ_q;
         logic                     load_main_in;
         logic                     load_main_skid;
         logic                     load_skid;

         always_comb begin
            state_nxt      = state_q;
            load_main_in   = 1'b0;
            load_main_skid = 1'b0;
            load_skid      = 1'b0;
            case (state_q)
               EMPTY: begin
                  if (in_xfer) begin
                     load_main_in = 1'b1;
                     state_nxt    = ONE;
                  end
               end
               ONE: begin
                  if (in_xfer && out_xfer) begin
                     load_main_in = 1'b1;
                  end else if (in_xfer) begin
                     load_skid = 1'b1;
                     state_nxt = FULL;
                  end else if (out_xfer) begin
                     state_nxt = EMPTY;
                  end
               end
               FULL: begin
                  if (out_xfer) begin
                     load_main_skid = 1'b1;
                     state_nxt      = ONE;
                  end
               end
               default: state_nxt = EMPTY;
            endcase
            // Flush drops everything held and any arriving entry; data registers keep their contents.
            if (flush) begin
               state_nxt      = EMPTY;
               load_main_in   = 1'b0;
               load_main_skid = 1'b0;
               load_skid      = 1'b0;
            end
         end

         // Handshake outputs are registered from the next state so in_ready never sees out_ready.
         always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
               state_q <= EMPTY;
               main_q  <= RESET_PAYLOAD;
               skid_q  <= RESET_PAYLOAD;
               rdy_q   <= 1'b0;
               vld_q   <= 1'b0;
               occ_q   <= 2'd0;
            end else begin
               state_q <= state_nxt;
               rdy_q   <= (state_nxt != FULL);
               vld_q   <= (state_nxt != EMPTY);
               case (state_nxt)
                  ONE:     occ_q <= 2'd1;
                  FULL:    occ_q <= 2'd2;
                  default: occ_q <= 2'd0;
               endcase
               if (load_main_in)
                  main_q <= in_payload;
               else if (load_main_skid)
                  main_q <= skid_q;
               if (load_skid)
                  skid_q <= in_payload;
            end
         end

         assign in_ready = rdy_q;
         assign occ      = occ_q;
      end else begin : g_single
         always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
               main_q <= RESET_PAYLOAD;
               vld_q  <= 1'b0;
            end else if (flush) begin
               vld_q <= 1'b0;
            end else if (in_xfer) begin
               main_q <= in_payload;
               vld_q  <= 1'b1;
            end else if (out_xfer) begin
               vld_q <= 1'b0;
            end
         end

         assign in_ready = !vld_q || out_ready;
         assign occ      = {1'b0, vld_q};
      end
   endgenerate

   // A bubble shows the stale main register above a fixed control code.
   always_comb begin
      out_payload = main_q;
      if (!vld_q)
         out_payload[CTRL_WIDTH-1:0] = BUBBLE_CTRL;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         stall_q <= 16'd0;
      else if (clear_stats)
         stall_q <= 16'd0;
      else if (vld_q && !out_ready && stall_q != 16'hFFFF)
         stall_q <= stall_q + 16'd1;
   end

   assign stall_cycles = stall_q;

endmodule

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 SHALL have parameter PAYLOAD_WIDTH, default 160, total stage payload width in bits.
REQ-002 SHALL have parameter CTRL_WIDTH, default 12, width of the control field, payload bits [CTRL_WIDTH-1:0].
REQ-003 SHALL have parameter BUBBLE_CTRL, default 0, control-field value presented for a bubble.
REQ-004 SHALL have parameter RESET_PAYLOAD, default 0, payload register value after reset.
REQ-005 SHALL have parameter SKID, default 1: 1 selects a two-entry skid buffer with registered in_ready; 0 selects a single register with combinational in_ready.
REQ-006 SHALL use one clock and an asynchronous, active-high reset; clock and reset ports are named clk and reset.
REQ-007 Ports SHALL be:
clk  in  1  clock, rising edge
reset  in  1  asynchronous active-high reset
flush  in  1  synchronous discard of all held entries
clear_stats  in  1  synchronous clear of stall_cycles
in_valid  in  1  upstream entry valid
in_ready  out  1  stage can accept an entry
in_payload  in  PAYLOAD_WIDTH  upstream entry
out_valid  out  1  downstream entry valid
out_ready  in  1  downstream accepts the entry
out_payload  out  PAYLOAD_WIDTH  head entry
occupancy  out  2  entries held (0..2)
stall_cycles  out  16  saturating count of back-pressure cycles

Function
REQ-008 Input transfer SHALL occur on a rising clk edge with in_valid && in_ready; output transfer SHALL occur with out_valid && out_ready.
REQ-009 SKID=1 SHALL implement states EMPTY (occupancy 0), ONE (1) and FULL (2), with a main register driving out_payload and a skid register.
REQ-010 SKID=1 in_ready SHALL be a register output equal to (state != FULL), with no combinational path from out_ready.
REQ-011 EMPTY: on input transfer, main <= in_payload and state -> ONE; otherwise hold.
REQ-012 ONE: on input and output transfer, main <= in_payload and stay ONE; on input only, skid <= in_payload and state -> FULL; on output only, state -> EMPTY.
REQ-013 FULL: on output transfer, main <= skid and state -> ONE; no input transfer is possible.
REQ-014 SKID=0 SHALL hold one entry, with in_ready = !out_valid || out_ready (combinational); occupancy SHALL be 0 or 1.
REQ-015 out_valid SHALL be 1 exactly when occupancy > 0; entries SHALL leave in arrival order, with none lost or duplicated.
REQ-016 When out_valid = 0, out_payload[CTRL_WIDTH-1:0] SHALL equal BUBBLE_CTRL and the upper bits SHALL show the main register contents.
REQ-017 flush SHALL take priority over all transfers: next state EMPTY; a same-cycle input transfer is discarded; payload data registers hold their values.
REQ-018 A same-cycle output transfer during flush SHALL count as consumed by the downstream stage.
REQ-019 stall_cycles SHALL increment by 1 on each cycle with out_valid && !out_ready, and saturate at 16'hFFFF.
REQ-020 clear_stats SHALL set stall_cycles to 0 and take priority over a same-cycle increment.
REQ-021 flush SHALL not affect stall_cycles.
REQ-022 Payload width SHALL be fully parametric, with CTRL_WIDTH <= PAYLOAD_WIDTH; no arithmetic is applied to the payload.

Reset
REQ-023 reset SHALL immediately, without a clock edge, force state EMPTY, occupancy 0, out_valid 0, main and skid registers = RESET_PAYLOAD, and stall_cycles 0.
REQ-024 During reset, SKID=1 in_ready SHALL be 0; it SHALL become 1 on the first clk edge after reset deasserts.
REQ-025 reset asserted mid-operation SHALL discard all held entries with no output transfer.

Verification
REQ-026 SKID=1, out_ready=1, in_valid held for 8 cycles with payloads 1..8 -> out_payload 1..8 on consecutive cycles, one cycle latency, occupancy 1.
REQ-027 SKID=1, out_ready=0, push 0xA then 0xB -> occupancy 2, in_ready 0, stall_cycles increments each cycle; set out_ready=1 -> 0xA then 0xB, then occupancy 0.
REQ-028 FULL state, flush=1 with in_valid=1 payload 0xC -> next cycle out_valid 0, out_payload control field = BUBBLE_CTRL, 0xC never appears at the output.
REQ-029 Hold out_valid=1, out_ready=0 for 70000 cycles -> stall_cycles = 16'hFFFF; clear_stats=1 -> 0 on the next cycle.
REQ-030 SKID=0, out_ready toggled randomly, 1000 random entries -> output sequence equals input sequence, and in_ready equals !out_valid || out_ready in every cycle.
REQ-031 reset pulsed asynchronously mid-cycle in FULL state -> out_valid 0 and occupancy 0 before the next edge; out_payload = RESET_PAYLOAD with the control field = BUBBLE_CTRL.
